// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
module regfile_mp_scoreboard #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [XLEN-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busyCnt_q, busyCnt_d;
  logic [ADDR_W-1:0] wrAddrA [NUM_WR];
  logic [XLEN-1:0]   wrDataA [NUM_WR];
  logic [ADDR_W-1:0] rdAddrA [NUM_RD];

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wrAddrA[j] = wr_addr[j*ADDR_W +: ADDR_W];
      wrDataA[j] = wr_data[j*XLEN +: XLEN];
    end
    for (int k = 0; k < NUM_RD; k++) begin
      rdAddrA[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Writes clear first so a same-cycle reserve from a younger instruction wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) busy_d[wrAddrA[j]] = 1'b0;
    end
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    busyCnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busyCnt_d = busyCnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  // Later ports overwrite earlier ones, so the highest-indexed writer wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      busyCnt_q <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !isZeroReg(wrAddrA[j])) regs_q[wrAddrA[j]] <= wrDataA[j];
      end
      busy_q    <= busy_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!reset && !isZeroReg(rdAddrA[k])) begin
        rd_data[k*XLEN +: XLEN] = regs_q[rdAddrA[k]];
        rd_busy[k]              = busy_q[rdAddrA[k]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wrAddrA[j] == rdAddrA[k])) begin
              rd_data[k*XLEN +: XLEN] = wrDataA[j];
              rd_busy[k]              = 1'b0;
            end
          end
        end
      end
    end
  end

  assign busy_cnt = busyCnt_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: two instances (default, and ZERO_REG=0/BYPASS=0) share stimulus;
// expected outputs are queued by the driver and compared by a negedge monitor.
module tb_regfile_mp_scoreboard;

  localparam int DEPTH = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rdAddr = '0;
  logic [1:0]  wrEn = '0;
  logic [9:0]  wrAddr = '0;
  logic [63:0] wrData = '0;
  logic        rsvEn = 1'b0;
  logic [4:0]  rsvAddr = '0;
  logic [63:0] rdDataA, rdDataB;
  logic [1:0]  rdBusyA, rdBusyB;
  logic [5:0]  busyCntA, busyCntB;

  always #5 clock = ~clock;

  regfile_mp_scoreboard dutA (
    .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
    .busy_cnt(busyCntA)
  );

  regfile_mp_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dutB (
    .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
    .busy_cnt(busyCntB)
  );

  typedef struct {
    logic [63:0] dataA, dataB;
    logic [1:0]  busyA, busyB;
    logic [5:0]  cntA, cntB;
    bit          cntKnown;
    int          cyc;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] memM  [2][DEPTH];
  bit          busyM [2][DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  bit          cntKnown = 0;

  // Model index 0 mirrors dutA (zero reg, bypass); index 1 mirrors dutB.
  function automatic void modelEdge();
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int a = 0; a < DEPTH; a++) begin
          memM[m][a]  = 32'h0;
          busyM[m][a] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          int a = int'(wrAddr[j*5 +: 5]);
          if (wrEn[j]) begin
            if (!(m == 0 && a == 0)) memM[m][a] = wrData[j*32 +: 32];
            busyM[m][a] = 1'b0;
          end
        end
        if (rsvEn && !(m == 0 && rsvAddr == 5'd0)) busyM[m][rsvAddr] = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] modelRead(input int m, input int k);
    int a = int'(rdAddr[k*5 +: 5]);
    logic [31:0] v;
    if (reset || (m == 0 && a == 0)) return 32'h0;
    v = memM[m][a];
    if (m == 0) begin
      for (int j = 0; j < 2; j++)
        if (wrEn[j] && int'(wrAddr[j*5 +: 5]) == a) v = wrData[j*32 +: 32];
    end
    return v;
  endfunction

  function automatic logic modelBusy(input int m, input int k);
    int a = int'(rdAddr[k*5 +: 5]);
    if (reset || (m == 0 && a == 0)) return 1'b0;
    if (m == 0 && ((wrEn[0] && int'(wrAddr[4:0]) == a) || (wrEn[1] && int'(wrAddr[9:5]) == a)))
      return 1'b0;
    return busyM[m][a];
  endfunction

  function automatic logic [5:0] modelCount(input int m);
    int n = 0;
    for (int a = 0; a < DEPTH; a++) n += int'(busyM[m][a]);
    return 6'(n);
  endfunction

  task automatic applyStimulus(input bit rst, input logic [1:0] we, input logic [9:0] wa,
                               input logic [63:0] wd, input bit re, input logic [4:0] ra,
                               input logic [9:0] rda);
    exp_t e;
    @(posedge clock);
    #1;
    modelEdge();
    if (reset) cntKnown = 1;
    reset = rst; wrEn = we; wrAddr = wa; wrData = wd; rsvEn = re; rsvAddr = ra; rdAddr = rda;
    e.dataA    = {modelRead(0, 1), modelRead(0, 0)};
    e.dataB    = {modelRead(1, 1), modelRead(1, 0)};
    e.busyA    = {modelBusy(0, 1), modelBusy(0, 0)};
    e.busyB    = {modelBusy(1, 1), modelBusy(1, 0)};
    e.cntA     = modelCount(0);
    e.cntB     = modelCount(1);
    e.cntKnown = cntKnown;
    e.cyc      = cycle;
    cycle++;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("A.rd_data0", e.cyc, 64'(rdDataA[31:0]),  64'(e.dataA[31:0]));
        checkOutput("A.rd_data1", e.cyc, 64'(rdDataA[63:32]), 64'(e.dataA[63:32]));
        checkOutput("A.rd_busy",  e.cyc, 64'(rdBusyA),        64'(e.busyA));
        checkOutput("B.rd_data0", e.cyc, 64'(rdDataB[31:0]),  64'(e.dataB[31:0]));
        checkOutput("B.rd_data1", e.cyc, 64'(rdDataB[63:32]), 64'(e.dataB[63:32]));
        checkOutput("B.rd_busy",  e.cyc, 64'(rdBusyB),        64'(e.busyB));
        if (e.cntKnown) begin
          checkOutput("A.busy_cnt", e.cyc, 64'(busyCntA), 64'(e.cntA));
          checkOutput("B.busy_cnt", e.cyc, 64'(busyCntB), 64'(e.cntB));
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] a0, a1, r0, r1;
    $display("[TB] start");
    applyStimulus(1, 2'b00, 10'd0, 64'd0, 0, 5'd0, 10'd0);
    applyStimulus(1, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd5, 5'd5});
    // Basic write and read-back
    applyStimulus(0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 0, 5'd0, {5'd5, 5'd5});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd0, 5'd5});
    // Register 0 write and reserve
    applyStimulus(0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1234}, 1, 5'd0, {5'd0, 5'd0});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd0, 5'd0});
    // Bypass versus stored value
    applyStimulus(0, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h00000BAD}, 0, 5'd0, {5'd0, 5'd0});
    applyStimulus(0, 2'b00, {5'd0, 5'd7}, {32'h0, 32'hA5A5A5A5}, 0, 5'd0, {5'd7, 5'd0});
    applyStimulus(0, 2'b01, {5'd0, 5'd7}, {32'h0, 32'hA5A5A5A5}, 0, 5'd0, {5'd7, 5'd0});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd7, 5'd7});
    // Two writers to one register
    applyStimulus(0, 2'b11, {5'd9, 5'd9}, {32'h22, 32'h11}, 0, 5'd0, {5'd9, 5'd9});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd9, 5'd9});
    // Scoreboard reserve / write+reserve / release
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 1, 5'd3, {5'd3, 5'd3});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd0, 5'd3});
    applyStimulus(0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h33}, 1, 5'd3, {5'd0, 5'd3});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd0, 5'd3});
    applyStimulus(0, 2'b10, {5'd3, 5'd0}, {32'h44, 32'h0}, 0, 5'd0, {5'd0, 5'd3});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd0, 5'd3});
    // Reset in the middle of activity
    applyStimulus(0, 2'b11, {5'd2, 5'd1}, {32'h202, 32'h101}, 0, 5'd0, 10'd0);
    applyStimulus(0, 2'b11, {5'd4, 5'd3}, {32'h404, 32'h303}, 1, 5'd1, 10'd0);
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 1, 5'd2, 10'd0);
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 1, 5'd3, 10'd0);
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 1, 5'd4, {5'd2, 5'd1});
    applyStimulus(1, 2'b11, {5'd2, 5'd1}, {32'hFF, 32'hEE}, 1, 5'd5, {5'd4, 5'd3});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd2, 5'd1});
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd5, 5'd4});
    // Randomised traffic over a narrow address range to provoke collisions
    for (int i = 0; i < 400; i++) begin
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 49) == 0, 2'($urandom), {a1, a0},
                    {32'($urandom), 32'($urandom)}, 1'($urandom),
                    5'($urandom_range(0, 7)), {r1, r0});
    end
    applyStimulus(0, 2'b00, 10'd0, 64'd0, 0, 5'd0, {5'd1, 5'd2});
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
